// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter.
// Holds parameter defaults, requester indices and the contention-winner helper.
package rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 4;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LD  = 1'b1;

  // Grant decision for one cycle: which requester (if any) moves its write.
  typedef struct packed {
    logic gnt0;
    logic gnt1;
  } grant_t;

  // Contention winner: round-robin picks the requester that did not win last.
  function automatic logic rr_winner(input logic last_grant);
    return (last_grant == REQ_ALU) ? REQ_LD : REQ_ALU;
  endfunction

endpackage

// File: rtl/rf_wr_stage.sv
// Registered write stage: captures one granted address/data pair and pulses wr_en.
// Synchronous active-low clear; payload holds when no new write is loaded.
module rf_wr_stage
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data
);

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= i_load;
      if (i_load) begin
        r_wr_addr <= i_addr;
        r_wr_data <= i_data;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter (ALU and load writeback), one write per cycle.
// Define RF_WARB_FIXED_PRIO_EN for fixed priority (load wins); default is round-robin.
//
// Handshake: a transfer happens in a cycle where reqN_valid and reqN_ready are both
// high; ready is only ever raised for a valid requester, at most one at a time, and
// requesters hold valid/addr/data stable until they see ready.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rf_stall,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              last_grant
);

  logic              r_last_grant;
  logic              w_prio;
  grant_t            w_grant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

`ifdef RF_WARB_FIXED_PRIO_EN
  assign w_prio = REQ_LD;
`else
  assign w_prio = rr_winner(r_last_grant);
`endif

  // Reset low or a stalled register file blocks every grant.
  always_comb begin
    w_grant = '0;
    if (Reset && !rf_stall) begin
      if (req0_valid && req1_valid) begin
        w_grant.gnt0 = (w_prio == REQ_ALU);
        w_grant.gnt1 = (w_prio == REQ_LD);
      end else begin
        w_grant.gnt0 = req0_valid;
        w_grant.gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_grant.gnt0;
  assign req1_ready = w_grant.gnt1;
  assign w_xfer     = w_grant.gnt0 | w_grant.gnt1;
  assign w_addr     = w_grant.gnt1 ? req1_addr : req0_addr;
  assign w_data     = w_grant.gnt1 ? req1_data : req0_data;

  // Reset value REQ_LD lets the ALU win the first contention.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_last_grant <= REQ_LD;
    end else if (w_xfer) begin
      r_last_grant <= w_grant.gnt1 ? REQ_LD : REQ_ALU;
    end
  end

  assign last_grant = r_last_grant;

  rf_wr_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_wr_stage (
    .i_clk     (CLK),
    .i_rst_n   (Reset),
    .i_load    (w_xfer),
    .i_addr    (w_addr),
    .i_data    (w_data),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of grants and a queue of expected writes.
module tb_rf_write_arbiter;

`ifdef RF_WARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        CLK;
  logic        Reset;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_stall;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        last_grant;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic        d_rst, d_stall, d_v0, d_v1;
  logic [3:0]  d_a0, d_a1;
  logic [31:0] d_d0, d_d1;
  logic        m_r0, m_r1;
  logic        m_wr_en;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic        m_last;
  logic [35:0] exp_q[$];
  logic [31:0] rf_shadow[16];

  rf_write_arbiter dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_stall   (rf_stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .last_grant (last_grant)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- driver tasks ----------------
  // Apply inputs for one cycle and work out which requester should be granted.
  task automatic drive(input logic rst, input logic stall,
                       input logic v0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] a1, input logic [31:0] d1);
    Reset = rst; rf_stall = stall;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    d_rst = rst; d_stall = stall; d_v0 = v0; d_v1 = v1;
    d_a0 = a0; d_a1 = a1; d_d0 = d0; d_d1 = d1;
    m_r0 = 1'b0; m_r1 = 1'b0;
    if (rst && !stall) begin
      if (v0 && v1) begin
        if (FIXED) m_r1 = 1'b1;
        else if (m_last == 1'b1) m_r0 = 1'b1;
        else m_r1 = 1'b1;
      end else begin
        m_r0 = v0; m_r1 = v1;
      end
    end
    #1;
  endtask

  // Advance one clock edge and update the expected registered outputs.
  task automatic tick();
    @(posedge CLK);
    if (!d_rst) begin
      m_wr_en = 1'b0; m_addr = '0; m_data = '0; m_last = 1'b1;
      exp_q.delete();
    end else if (m_r0) begin
      m_wr_en = 1'b1; m_addr = d_a0; m_data = d_d0; m_last = 1'b0;
      exp_q.push_back({d_a0, d_d0});
    end else if (m_r1) begin
      m_wr_en = 1'b1; m_addr = d_a1; m_data = d_d1; m_last = 1'b1;
      exp_q.push_back({d_a1, d_d1});
    end else begin
      m_wr_en = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 4'd9, 32'h1234, 1'b1, 4'd10, 32'h5678);
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
        $display("FAIL reset_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
      tick();
    end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant: got %b want 1", last_grant); end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL single_ready: got r0=%b r1=%b want 1 0", req0_ready, req1_ready); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd3 || wr_data !== 32'hDEADBEEF) begin errors++;
      $display("FAIL single_write: got en=%b addr=%0d data=%h want 1 3 deadbeef", wr_en, wr_addr, wr_data); end
    checks++; if (last_grant !== 1'b0) begin errors++; $display("FAIL single_last: got %b want 0", last_grant); end
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 32'hCAFE);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin errors++;
      $display("FAIL single1_ready: got r0=%b r1=%b want 0 1", req0_ready, req1_ready); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL idle_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
    tick();
    checks++; if (wr_en !== 1'b0 || wr_addr !== 4'd6 || wr_data !== 32'hCAFE) begin errors++;
      $display("FAIL idle_hold: got en=%b addr=%0d data=%h want 0 6 cafe", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_g;
    exp_g = FIXED ? 4'b1111 : 4'b1010;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 4'd1, 32'h100 + k, 1'b1, 4'd2, 32'h200 + k);
      checks++; if (req0_ready !== !exp_g[k] || req1_ready !== exp_g[k]) begin errors++;
        $display("FAIL contend_ready[%0d]: got r0=%b r1=%b want grant %b", k, req0_ready, req1_ready, exp_g[k]); end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_addr !== (exp_g[k] ? 4'd2 : 4'd1) || last_grant !== exp_g[k]) begin errors++;
        $display("FAIL contend_write[%0d]: got en=%b addr=%0d last=%b want 1 grant %b", k, wr_en, wr_addr, last_grant, exp_g[k]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 4'd4, 32'hAA, 1'b1, 4'd8, 32'hBB);
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
        $display("FAIL stall_ready[%0d]: got r0=%b r1=%b want 0 0", k, req0_ready, req1_ready); end
      tick();
      checks++; if (wr_en !== 1'b0 || last_grant !== 1'b1) begin errors++;
        $display("FAIL stall_wr[%0d]: got en=%b last=%b want 0 1", k, wr_en, last_grant); end
    end
    drive(1'b1, 1'b0, 1'b1, 4'd4, 32'hAA, 1'b1, 4'd8, 32'hBB);
    checks++; if (req0_ready !== !FIXED || req1_ready !== FIXED) begin errors++;
      $display("FAIL unstall_ready: got r0=%b r1=%b want r1=%b", req0_ready, req1_ready, FIXED); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_data !== (FIXED ? 32'hBB : 32'hAA)) begin errors++;
      $display("FAIL unstall_write: got en=%b data=%h", wr_en, wr_data); end
  endtask

  task automatic test_same_addr();
    logic first;
    do_reset();
    for (int i = 0; i < 16; i++) rf_shadow[i] = 32'd0;
    first = FIXED ? 1'b1 : 1'b0;
    drive(1'b1, 1'b0, 1'b1, 4'd5, 32'h11, 1'b1, 4'd5, 32'h22);
    tick();
    if (wr_en) rf_shadow[wr_addr] = wr_data;
    checks++; if (wr_en !== 1'b1 || wr_data !== (first ? 32'h22 : 32'h11)) begin errors++;
      $display("FAIL same_first: got en=%b data=%h", wr_en, wr_data); end
    drive(1'b1, 1'b0, first, 4'd5, 32'h11, !first, 4'd5, 32'h22);
    checks++; if (req0_ready !== first || req1_ready !== !first) begin errors++;
      $display("FAIL same_second_ready: got r0=%b r1=%b", req0_ready, req1_ready); end
    tick();
    if (wr_en) rf_shadow[wr_addr] = wr_data;
    checks++; if (wr_en !== 1'b1 || wr_data !== (first ? 32'h11 : 32'h22)) begin errors++;
      $display("FAIL same_second: got en=%b data=%h", wr_en, wr_data); end
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    tick();
    checks++; if (rf_shadow[5] !== (FIXED ? 32'h11 : 32'h22) || wr_en !== 1'b0) begin errors++;
      $display("FAIL same_final: got rf[5]=%h en=%b", rf_shadow[5], wr_en); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'd0);
    tick();
    checks++; if (wr_en !== 1'b1 || last_grant !== 1'b0) begin errors++;
      $display("FAIL mid_grant: got en=%b last=%b want 1 0", wr_en, last_grant); end
    drive(1'b0, 1'b0, 1'b1, 4'd7, 32'h78, 1'b1, 4'd9, 32'h99);
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL mid_ready: got r0=%b r1=%b want 0 0", req0_ready, req1_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      tick();
      checks++; if (wr_en !== 1'b0 || last_grant !== 1'b1 || wr_addr !== 4'd0) begin errors++;
        $display("FAIL mid_release[%0d]: got en=%b last=%b addr=%0d want 0 1 0", k, wr_en, last_grant, wr_addr); end
    end
  endtask

  task automatic test_random();
    logic v0, v1, st;
    logic [3:0] a0, a1;
    logic [31:0] d0, d1;
    logic [35:0] exp_w;
    do_reset();
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 300; c++) begin
      // Ungranted requests stay stable; everything else is re-rolled.
      if (!(v0 && !m_r0)) begin
        v0 = ($urandom_range(0, 3) != 0); a0 = 4'($urandom_range(0, 15)); d0 = $urandom;
      end
      if (!(v1 && !m_r1)) begin
        v1 = ($urandom_range(0, 3) != 0); a1 = 4'($urandom_range(0, 15)); d1 = $urandom;
      end
      st = ($urandom_range(0, 4) == 0);
      drive(1'b1, st, v0, a0, d0, v1, a1, d1);
      checks++; if (req0_ready !== m_r0 || req1_ready !== m_r1) begin errors++;
        $display("FAIL rand_ready[%0d]: got r0=%b r1=%b want %b %b", c, req0_ready, req1_ready, m_r0, m_r1); end
      tick();
      checks++; if (wr_en !== m_wr_en || last_grant !== m_last) begin errors++;
        $display("FAIL rand_state[%0d]: got en=%b last=%b want %b %b", c, wr_en, last_grant, m_wr_en, m_last); end
      if (m_wr_en && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        checks++; if ({wr_addr, wr_data} !== exp_w) begin errors++;
          $display("FAIL rand_write[%0d]: got %h/%h want %h/%h", c, wr_addr, wr_data, exp_w[35:32], exp_w[31:0]); end
      end else begin
        checks++; if (wr_addr !== m_addr || wr_data !== m_data) begin errors++;
          $display("FAIL rand_hold[%0d]: got %h/%h want %h/%h", c, wr_addr, wr_data, m_addr, m_data); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    m_last = 1'b1; m_wr_en = 1'b0; m_addr = '0; m_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_stall();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register data width.
REQ-002 SHALL have parameter ADDR_W, default 4: register address width (16 registers).
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports req0_valid (in, 1), req0_addr (in, ADDR_W), req0_data (in, DATA_W): requester 0 (ALU writeback) write request.
REQ-006 SHALL have port req0_ready, out, 1: requester 0 grant; transfer occurs when req0_valid and req0_ready are high in the same cycle.
REQ-007 SHALL have ports req1_valid, req1_addr, req1_data and req1_ready, with the same widths and meaning for requester 1 (load writeback).
REQ-008 SHALL have port rf_stall, input, 1: when high, the register file accepts no write.
REQ-009 SHALL have ports wr_en (out, 1), wr_addr (out, ADDR_W), wr_data (out, DATA_W): registered write strobe and payload to the 32-bit register bank.
REQ-010 SHALL have port last_grant, out, 1: index of the most recently granted requester.

Function
REQ-011 SHALL grant at most one requester per cycle; req0_ready and req1_ready are never high together.
REQ-012 SHALL compute readies combinationally from the valids, rf_stall and the priority pointer, with no combinational path from valid to own ready other than the grant decision.
REQ-013 SHALL drive both readies low while rf_stall is high, regardless of the valids.
REQ-014 SHALL grant the sole valid requester immediately when only one is valid.
REQ-015 SHALL, when both requesters are valid, grant the requester the pointer selects; the pointer selects the requester not equal to last_grant.
REQ-016 SHALL update last_grant only on a completed transfer.
REQ-017 SHALL register the granted addr/data onto wr_addr/wr_data and assert wr_en for exactly one cycle, one cycle after the transfer (latency 1).
REQ-018 SHALL drive wr_en low in any cycle following a cycle with no transfer; wr_addr/wr_data hold their previous values.
REQ-019 SHALL issue same-address requests from both requesters as two writes in grant order; the last write wins.
REQ-020 SHALL support back-to-back transfers every cycle, for sustained throughput of one write per cycle.
REQ-021 SHALL require requesters to hold valid, addr and data stable until ready; the arbiter does not buffer ungranted requests.

Reset
REQ-022 SHALL, while Reset is low at a rising edge, clear wr_en to 0, wr_addr to 0, wr_data to 0 and last_grant to 1, so requester 0 wins the first contention.
REQ-023 SHALL drive both readies low during any cycle in which Reset is low.
REQ-024 SHALL discard any transfer in flight when reset is asserted mid-operation; no wr_en pulse follows reset release.

Configuration
REQ-025 SHALL, when RF_WARB_FIXED_PRIO_EN is defined, use fixed priority: requester 1 always wins contention and last_grant still reports the winner.
REQ-026 SHALL, when RF_WARB_FIXED_PRIO_EN is undefined, use the round-robin behaviour of REQ-015.

Structure
REQ-027 SHALL place the DATA_W and ADDR_W defaults and the requester index constants (REQ_ALU=0, REQ_LD=1) in the shared package rf_pkg.
REQ-028 SHALL contain the output stage as one sub-module, rf_wr_stage, a registered wr_en/addr/data stage with synchronous active-low clear.

Verification
REQ-029 SHALL cover: after reset, req0 valid with addr 3 and data 0xDEADBEEF -> req0_ready=1 the same cycle; wr_en=1, wr_addr=3, wr_data=0xDEADBEEF the next cycle.
REQ-030 SHALL cover: both requesters valid continuously for 4 cycles -> grants 0,1,0,1 (fixed-priority build: 1,1,1,1) and 4 consecutive wr_en pulses.
REQ-031 SHALL cover: rf_stall=1 for 3 cycles with both valid -> both readies 0 and wr_en 0 for those cycles; after stall drops, the round-robin winner is req0.
REQ-032 SHALL cover: both requesters write addr 5 (req0 0x11, req1 0x22) -> two wr_en pulses in grant order; the final wr_data to addr 5 is 0x22.
REQ-033 SHALL cover: Reset driven low the cycle after a grant -> no wr_en pulse follows, and last_grant=1 after release.
